// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: shares one ALU and its Y result register between two
// requesters. It grants round-robin, registers the operands and opcode toward
// the ALU, waits ALU_LAT cycles, captures the result, and holds it until the
// consumer takes it.
module alu_rr_sequencer #(
  parameter int W       = 4,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [W-1:0]   resp_y,
  output logic           busy
);

  // A zero-latency ALU is not supported: the capture always happens at least
  // one edge after the operands are registered.
  if (ALU_LAT < 1) begin : g_bad_lat
    $error("alu_rr_sequencer: ALU_LAT must be >= 1");
  end

  // The counter only ever holds ALU_LAT-1 down to 0.
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [W-1:0]   r_resp_y;
  logic           r_resp_id;

  logic           w_grant;
  logic           w_accept;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [OPW-1:0] w_sel_op;

  // Next-state, grant and ready decode; ready only ever appears in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_grant     = r_ptr;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // The pointer holder wins if it is asking; otherwise the other side.
        w_grant = (r_ptr ? req1_valid : req0_valid) ? r_ptr : ~r_ptr;
        if (!rst && (req0_valid || req1_valid)) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_grant;
          req1_ready  = w_grant;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Payload of the granted requester.
  always_comb begin
    w_sel_a  = w_grant ? req1_a  : req0_a;
    w_sel_b  = w_grant ? req1_b  : req0_b;
    w_sel_op = w_grant ? req1_op : req0_op;
  end

  // State register plus operand, counter, result and pointer updates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_resp_y  <= '0;
      r_resp_id <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_op  <= w_sel_op;
            r_resp_id <= w_grant;
            r_cnt     <= CNT_LOAD;
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) r_cnt    <= r_cnt - 1'b1;
          else             r_resp_y <= alu_result;
        end
        S_RESP: begin
          // Fairness only moves on a completed response.
          if (resp_ready) r_ptr <= ~r_resp_id;
        end
        default: ;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign resp_y     = r_resp_y;
  assign resp_id    = r_resp_id;
  assign resp_valid = (r_state == S_RESP);
  assign busy       = (r_state == S_EXEC) || (r_state == S_RESP);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: one instance at ALU_LAT=1 and one at
// ALU_LAT=3, each driving a small behavioural ALU.
module tb_alu_rr_sequencer;

  localparam int W   = 4;
  localparam int OPW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance signals
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic [W-1:0]   alu_a, alu_b, alu_result, resp_y;
  logic [OPW-1:0] alu_op;
  logic           resp_valid, resp_ready, resp_id, busy;

  // ALU_LAT = 3 instance signals
  logic           req0_valid_3, req0_ready_3, req1_valid_3, req1_ready_3;
  logic [W-1:0]   req0_a_3, req0_b_3, req1_a_3, req1_b_3;
  logic [OPW-1:0] req0_op_3, req1_op_3;
  logic [W-1:0]   alu_a_3, alu_b_3, alu_result_3, resp_y_3;
  logic [OPW-1:0] alu_op_3;
  logic           resp_valid_3, resp_ready_3, resp_id_3, busy_3;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_op);
  assign alu_result_3 = alu_model(alu_a_3, alu_b_3, alu_op_3);

  alu_rr_sequencer #(.W(W), .OPW(OPW), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y), .busy(busy)
  );

  alu_rr_sequencer #(.W(W), .OPW(OPW), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_a(req0_a_3), .req0_b(req0_b_3), .req0_op(req0_op_3),
    .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_a(req1_a_3), .req1_b(req1_b_3), .req1_op(req1_op_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3), .alu_result(alu_result_3),
    .resp_valid(resp_valid_3), .resp_ready(resp_ready_3), .resp_id(resp_id_3), .resp_y(resp_y_3), .busy(busy_3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge and settle; checks and new inputs happen 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready = 1'b0;
    req0_valid_3 = 1'b0; req0_a_3 = '0; req0_b_3 = '0; req0_op_3 = '0;
    req1_valid_3 = 1'b0; req1_a_3 = '0; req1_b_3 = '0; req1_op_3 = '0;
    resp_ready_3 = 1'b0;

    // 1: reset with a request pending
    #1;
    check("rst_ready_pre", 32'(req0_ready), 0);
    step(2);
    check("rst_ready", 32'(req0_ready), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_resp_y", 32'(resp_y), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0; req0_valid = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 0);

    // 2: ALU_LAT=1, req0 3+4
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'd0;
    #1;
    check("t2_ready0", 32'(req0_ready), 1);
    check("t2_ready1", 32'(req1_ready), 0);
    step();  // E0
    req0_valid = 1'b0;
    #1;
    check("t2_alu_a", 32'(alu_a), 3);
    check("t2_alu_b", 32'(alu_b), 4);
    check("t2_busy_exec", 32'(busy), 1);
    check("t2_valid_exec", 32'(resp_valid), 0);
    check("t2_ready_exec", 32'(req0_ready), 0);
    step();  // E1
    check("t2_resp_valid", 32'(resp_valid), 1);
    check("t2_resp_y", 32'(resp_y), 7);
    check("t2_resp_id", 32'(resp_id), 0);
    resp_ready = 1'b1;
    step();
    check("t2_done_valid", 32'(resp_valid), 0);
    check("t2_done_busy", 32'(busy), 0);

    // 4: req1 alone (ptr=1), 9-5, response stalled for 5 cycles
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd5; req1_op = 3'd1;
    #1;
    check("t4_ready1", 32'(req1_ready), 1);
    check("t4_ready0", 32'(req0_ready), 0);
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd10; req0_op = 3'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_stall_valid", 32'(resp_valid), 1);
      check("t4_stall_y", 32'(resp_y), 4);
      check("t4_stall_id", 32'(resp_id), 1);
      check("t4_stall_ready0", 32'(req0_ready), 0);
      step();
    end
    resp_ready = 1'b1;
    step();  // handshake, ptr -> 0

    // 3: both valid with ptr=0; req0 12&10, req1 6|3
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3; req1_op = 3'd3;
    #1;
    check("t3_ready0", 32'(req0_ready), 1);
    check("t3_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    #1;
    check("t3_exec_ready1", 32'(req1_ready), 0);
    step();
    check("t3_y0", 32'(resp_y), 8);
    check("t3_id0", 32'(resp_id), 0);
    step();
    check("t3_ready1_turn", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    step();
    check("t3_y1", 32'(resp_y), 7);
    check("t3_id1", 32'(resp_id), 1);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t3_ptr_back_r0", 32'(req0_ready), 1);
    check("t3_ptr_back_r1", 32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;  // withdrawn without handshake
    step();
    check("t3_withdraw_busy", 32'(busy), 0);

    // 5: ALU_LAT=3, 9+8 wraps to 1
    resp_ready_3 = 1'b1;
    req0_valid_3 = 1'b1; req0_a_3 = 4'd9; req0_b_3 = 4'd8; req0_op_3 = 3'd0;
    #1;
    check("t5_ready0", 32'(req0_ready_3), 1);
    step();  // E0
    req0_valid_3 = 1'b0;
    check("t5_busy_e0", 32'(busy_3), 1);
    check("t5_valid_e0", 32'(resp_valid_3), 0);
    step();  // E1
    check("t5_valid_e1", 32'(resp_valid_3), 0);
    step();  // E2
    check("t5_valid_e2", 32'(resp_valid_3), 0);
    check("t5_busy_e2", 32'(busy_3), 1);
    step();  // E3
    check("t5_valid_e3", 32'(resp_valid_3), 1);
    check("t5_y", 32'(resp_y_3), 1);
    check("t5_busy_e3", 32'(busy_3), 1);
    step();  // E4 handshake
    check("t5_busy_done", 32'(busy_3), 0);

    // 6: reset during EXEC (ptr=1 so req1 is served)
    req1_valid_3 = 1'b1; req1_a_3 = 4'd5; req1_b_3 = 4'd2; req1_op_3 = 3'd1;
    step();
    req1_valid_3 = 1'b0;
    check("t6_alu_a_loaded", 32'(alu_a_3), 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", 32'(busy_3), 0);
    check("t6_alu_a", 32'(alu_a_3), 0);
    check("t6_valid", 32'(resp_valid_3), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_resp", 32'(resp_valid_3), 0);
    end
    req0_valid_3 = 1'b1; req1_valid_3 = 1'b1;
    #1;
    check("t6_ptr_reset", 32'(req0_ready_3), 1);
    req0_valid_3 = 1'b0; req1_valid_3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
